// File: rtl/uart_pkg.sv
// Shared UART-side definitions: byte width, arbiter defaults and state encoding.
package uart_pkg;

    localparam int UART_DW       = 8;
    localparam int DEF_MAX_BURST = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND      = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_HOLD      = 3'd4
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Rotating-priority encoder: first asserted request scanning upward from ptr+1
// (mod N); ptr itself has the lowest priority. Purely combinational.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] idx,
    output logic          any
);

    logic [PW-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest requester wins last.
    always_comb begin
        idx  = ptr;
        cand = ptr;
        any  = |req;
        for (int k = N; k >= 1; k--) begin
            cand = PW'((int'(ptr) + k) % N);
            if (req[cand]) idx = cand;
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter among N byte-stream clients.
// A grant is held for a whole packet (until last or MAX_BURST bytes), and each
// byte is walked through tx_start -> tx_busy high -> tx_busy low.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int N         = 4,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N-1:0]           req_valid,
    input  logic [N*UART_DW-1:0]   req_data,
    input  logic [N-1:0]           req_last,
    output logic [N-1:0]           req_ready,
    output logic                   tx_start,
    output logic [UART_DW-1:0]     tx_data,
    input  logic                   tx_busy,
    output logic [$clog2(N)-1:0]   grant_id,
    output logic                   grant_active
);

    localparam int GW = $clog2(N);

    arb_state_t                state, state_nxt;
    logic [GW-1:0]             ptr;
    logic [7:0]                burst_cnt;
    logic                      last_seen;
    logic [GW-1:0]             pick_idx;
    logic                      pick_any;
    logic [GW-1:0]             src_id;
    logic [N-1:0][UART_DW-1:0] lane_data;

    for (genvar g = 0; g < N; g++) begin : g_lane
        assign lane_data[g] = req_data[g*UART_DW +: UART_DW];
    end

    rr_pick #(
        .N  (N),
        .PW (GW)
    ) u_pick (
        .req (req_valid),
        .ptr (ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    // The byte about to be sent comes from the fresh pick in IDLE, else the owner.
    assign src_id = (state == ST_IDLE) ? pick_idx : grant_id;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; WAIT_* ignore req_valid so a client may drop it mid-frame.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (pick_any) state_nxt = ST_SEND;
            ST_SEND:      state_nxt = ST_WAIT_BUSY;
            ST_WAIT_BUSY: if (tx_busy) state_nxt = ST_WAIT_DONE;
            ST_WAIT_DONE: if (!tx_busy) state_nxt = last_seen ? ST_IDLE : ST_HOLD;
            ST_HOLD:      if (req_valid[grant_id]) state_nxt = ST_SEND;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    // Registered outputs and grant bookkeeping. ready/start/data are loaded on
    // the edge into SEND so they are all valid during the SEND cycle itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready    <= '0;
            tx_start     <= 1'b0;
            tx_data      <= '0;
            grant_id     <= '0;
            grant_active <= 1'b0;
            ptr          <= GW'(N - 1);
            burst_cnt    <= '0;
            last_seen    <= 1'b0;
        end else begin
            req_ready <= '0;
            tx_start  <= 1'b0;
            if (state_nxt == ST_SEND) begin
                req_ready <= N'(1) << src_id;
                tx_start  <= 1'b1;
                tx_data   <= lane_data[src_id];
            end
            if (state == ST_IDLE && pick_any) begin
                grant_id     <= pick_idx;
                burst_cnt    <= '0;
                grant_active <= 1'b1;
            end
            if (state == ST_SEND) begin
                // Compare in 9 bits so MAX_BURST=255 cannot alias on wrap.
                last_seen <= req_last[grant_id] |
                             (({1'b0, burst_cnt} + 9'd1) == 9'(MAX_BURST));
                burst_cnt <= burst_cnt + 8'd1;
            end
            if (state == ST_WAIT_DONE && !tx_busy && last_seen) begin
                ptr          <= grant_id;
                grant_active <= 1'b0;
            end
        end
    end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin arbiter that shares one UART transmitter among N byte-stream requesters. Each requester offers bytes over a valid/ready handshake. The arbiter keeps its grant for one packet, which ends on `last` or after `MAX_BURST` bytes. For each accepted byte it sequences the transmitter through start → busy → idle. It sits between the peripheral clients (command responder, debug console, status reporter) and the single `uart_tx` / baud-tick pair of the UART peripheral.

## Interface
- `N`, default 4: number of requesters, 2..8.
- `MAX_BURST`, default 16: maximum bytes per grant before forced release, 1..255.
- `clk` input 1: single clock domain.
- `rst_n` input 1: reset is asynchronous and active-low.
- `req_valid` input N: requester i has a byte on its slice.
- `req_data` input 8*N: byte i at bits [8i+7:8i].
- `req_last` input N: byte i is the final byte of its packet.
- `req_ready` output N: one-hot accept pulse, 1 cycle.
- `tx_start` output 1: 1-cycle pulse to the transmitter.
- `tx_data` output 8: registered byte, stable from `tx_start` until the transmitter returns idle.
- `tx_busy` input 1: transmitter is shifting a frame, including stop bits.
- `grant_id` output clog2(N): current owner; holds its last value when idle.
- `grant_active` output 1: a packet is in progress.

## Operation
- States are IDLE, SEND, WAIT_BUSY, WAIT_DONE and HOLD.
- **IDLE**
  - If any `req_valid` is high, pick the first requester scanning from `ptr+1` modulo N.
  - Latch it into `grant_id`, clear `burst_cnt`, set `grant_active`, go to SEND.
- **SEND** (exactly 1 cycle)
  - Assert `req_ready[grant_id]` and `tx_start`.
  - Load `tx_data` from the granted slice.
  - Latch `last_seen = req_last[grant_id] | (burst_cnt+1 == MAX_BURST)`.
  - Increment `burst_cnt`, go to WAIT_BUSY.
- **WAIT_BUSY**: wait for `tx_busy==1`, then go to WAIT_DONE.
- **WAIT_DONE**: wait for `tx_busy==0`.
  - If `last_seen`: go to IDLE, `ptr <= grant_id`, clear `grant_active`.
  - Otherwise go to HOLD.
- **HOLD**
  - The grant stays locked; other requesters are ignored.
  - When `req_valid[grant_id]` is high, go to SEND.
  - No timeout: a client that stalls mid-packet stalls the UART by design.
- `req_valid` of the owner is sampled only in IDLE, SEND and HOLD. A drop while in WAIT_* is legal and has no effect.
- `burst_cnt` is 8 bits. Forced release at `MAX_BURST` applies even without `last`. The next grant then follows round-robin order, so the same requester can only be re-granted after the others have had a chance.
- Simultaneous requests in IDLE are resolved by the rotating priority. `ptr` resets to N-1, so requester 0 wins first.

## Timing
- Reset values:
  - state IDLE; `req_ready` 0; `tx_start` 0; `tx_data` 0x00.
  - `grant_id` 0; `grant_active` 0.
  - `ptr` N-1; `burst_cnt` 0; `last_seen` 0.
- Latency from `req_valid` in IDLE:
  - grant registered on edge 1;
  - `req_ready` and `tx_start` high in cycle 2.
- From HOLD with valid high: `tx_start` asserts the next cycle.
- Back-to-back bytes of one packet: the gap is 2 cycles after `tx_busy` falls (WAIT_DONE→HOLD→SEND).
- `tx_start` and `req_ready[grant_id]` are always coincident and never high for more than 1 cycle.
- Reset mid-frame aborts immediately: outputs return to reset values and the byte in flight is lost. The transmitter is reset by the same `rst_n`.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared `uart_pkg` holds:
  - the state encoding typedef (`arb_state_t`, 3 bits);
  - the default `MAX_BURST`;
  - the byte width constant `UART_DW = 8`.
- One sub-module, `rr_pick`: a combinational rotating-priority encoder.
  - Inputs: `req` [N], `ptr`.
  - Outputs: `idx`, `any`.
  - It is reusable for other shared-peripheral arbiters.

## Test plan
- **Single byte**: req0 sends 0x55 with `last`.
  - `tx_start` fires once with `tx_data=0x55`.
  - `grant_active` falls after `tx_busy` falls; `ptr=0`.
- **Contention**: req0 and req2 are both valid from reset with 1-byte packets.
  - Service order is 0, 2, 0, 2.
  - `req_ready` stays one-hot throughout.
- **Packet lock**: req1 sends 0x11, 0x22, 0x33 (`last` on 0x33) while req3 is valid throughout.
  - All three bytes go out before any req3 byte.
  - `grant_id` stays 1.
- **Forced release**: `MAX_BURST=2`; req0 streams 5 bytes with no `last` while req1 is valid.
  - Output order is 0,0,1,0,0,…
  - Release occurs after byte 2.
- **HOLD stall**: req2 drops `req_valid` mid-packet for 50 cycles.
  - No `tx_start` occurs during the stall.
  - No other requester is granted.
  - Transmission resumes 1 cycle after valid returns.
- **Async reset**: `rst_n` is asserted during WAIT_DONE.
  - All outputs go to reset values without waiting for a clock edge.
  - After release, requester 0 has priority.
